systolic_mm_engine: RTL and testbench

//  Self-sequencing output-stationary NxN systolic matrix-multiply engine: computes C = A(NxK) * B(KxN), K set at run time.

---
 rtl/systolic_mm_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine
// Output-stationary NxN systolic matrix multiplier, C = A(NxK) * B(KxN).
// Operands arrive unskewed, one A column and one B row per beat. The engine
// skews them internally, flushes the array, then drains C one row at a time.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; results of the previous job stay visible
// S_CLEAR | one cycle; zero accumulators, skew and PE pipe registers
// S_FEED  | accepting K operand beats (in_ready=1)
// S_FLUSH | 2N-1 cycles of zero operands so every product reaches its PE
// S_DRAIN | presenting C rows 0..N-1 on out_row with out_valid=1
module systolic_mm_engine #(
    parameter int N      = 16,
    parameter int DW     = 8,
    parameter int AW     = 32,
    parameter int KMAX   = 256,
    parameter int SIGNED = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [$clog2(KMAX+1)-1:0] k_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N*DW-1:0]           a_col,
    input  logic [N*DW-1:0]           b_row,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N*AW-1:0]           out_row,
    output logic [$clog2(N)-1:0]      out_idx,
    output logic                      busy,
    output logic                      done
);

    localparam int KLW = $clog2(KMAX+1);
    localparam int IW  = $clog2(N);
    localparam int FW  = $clog2(2*N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t         state;
    logic [KLW-1:0] k_cnt;
    logic [FW-1:0]  fl_cnt;
    logic [KLW-1:0] k_eff;

    logic feeding;
    logic adv;
    logic clr;

    assign k_eff   = (k_len > KLW'(KMAX)) ? KLW'(KMAX) : k_len;
    assign feeding = (state == S_FEED);
    assign adv     = (feeding && in_valid) || (state == S_FLUSH);
    assign clr     = (state == S_CLEAR);

    // Sequencer: beat and flush timers are down-counters, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            k_cnt     <= '0;
            fl_cnt    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_CLEAR;
                        k_cnt <= k_eff;
                        busy  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (k_cnt == '0) begin
                        state     <= S_DRAIN;
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                    end else begin
                        state    <= S_FEED;
                        in_ready <= 1'b1;
                    end
                end
                S_FEED: begin
                    if (in_valid) begin
                        k_cnt <= k_cnt - 1'b1;
                        if (k_cnt == KLW'(1)) begin
                            state    <= S_FLUSH;
                            in_ready <= 1'b0;
                            fl_cnt   <= FW'(2*N-2);
                        end
                    end
                end
                S_FLUSH: begin
                    if (fl_cnt == '0) begin
                        state     <= S_DRAIN;
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                    end else begin
                        fl_cnt <= fl_cnt - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (out_idx == IW'(N-1)) begin
                            state     <= S_IDLE;
                            out_valid <= 1'b0;
                            out_idx   <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_idx <= out_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // a_link[i][j] / b_link[i][j] are the operands entering PE(i,j) this cycle.
    logic [DW-1:0] a_link  [N][N];
    logic [DW-1:0] b_link  [N][N];
    logic [AW-1:0] acc_all [N][N];

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_skew
            logic [DW-1:0] a_in;
            logic [DW-1:0] b_in;
            assign a_in = feeding ? a_col[gi*DW +: DW] : '0;
            assign b_in = feeding ? b_row[gi*DW +: DW] : '0;

            if (gi == 0) begin : g_nodly
                assign a_link[0][0] = a_in;
                assign b_link[0][0] = b_in;
            end else begin : g_dly
                logic [DW-1:0] sr_a [gi];
                logic [DW-1:0] sr_b [gi];

                // Delay row gi of A and column gi of B by gi advancing cycles.
                always_ff @(posedge clk) begin
                    if (rst || clr) begin
                        for (int d = 0; d < gi; d++) begin
                            sr_a[d] <= '0;
                            sr_b[d] <= '0;
                        end
                    end else if (adv) begin
                        sr_a[0] <= a_in;
                        sr_b[0] <= b_in;
                        for (int d = 1; d < gi; d++) begin
                            sr_a[d] <= sr_a[d-1];
                            sr_b[d] <= sr_b[d-1];
                        end
                    end
                end

                assign a_link[gi][0] = sr_a[gi-1];
                assign b_link[0][gi] = sr_b[gi-1];
            end
        end

        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                logic [DW-1:0]   a_op;
                logic [DW-1:0]   b_op;
                logic [2*DW-1:0] ax;
                logic [2*DW-1:0] bx;
                logic [2*DW-1:0] prod;
                logic [AW-1:0]   pext;
                logic [AW-1:0]   acc_q;

                assign a_op = a_link[gi][gj];
                assign b_op = b_link[gi][gj];

                // Low 2*DW bits of the product are identical for signed and
                // unsigned operands once both are extended to 2*DW bits.
                assign ax   = {{DW{(SIGNED != 0) & a_op[DW-1]}}, a_op};
                assign bx   = {{DW{(SIGNED != 0) & b_op[DW-1]}}, b_op};
                assign prod = ax * bx;

                if (AW > 2*DW) begin : g_ext
                    assign pext = {{(AW-2*DW){(SIGNED != 0) & prod[2*DW-1]}}, prod};
                end else begin : g_noext
                    assign pext = prod;
                end

                // Output-stationary accumulate, wrapping modulo 2^AW.
                always_ff @(posedge clk) begin
                    if (rst || clr) begin
                        acc_q <= '0;
                    end else if (adv) begin
                        acc_q <= acc_q + pext;
                    end
                end

                assign acc_all[gi][gj] = acc_q;

                if (gj < N-1) begin : g_apass
                    logic [DW-1:0] a_q;
                    // A operand moves one PE to the right per advancing cycle.
                    always_ff @(posedge clk) begin
                        if (rst || clr) begin
                            a_q <= '0;
                        end else if (adv) begin
                            a_q <= a_op;
                        end
                    end
                    assign a_link[gi][gj+1] = a_q;
                end

                if (gi < N-1) begin : g_bpass
                    logic [DW-1:0] b_q;
                    // B operand moves one PE down per advancing cycle.
                    always_ff @(posedge clk) begin
                        if (rst || clr) begin
                            b_q <= '0;
                        end else if (adv) begin
                            b_q <= b_op;
                        end
                    end
                    assign b_link[gi+1][gj] = b_q;
                end
            end
        end

        for (gj = 0; gj < N; gj++) begin : g_out
            assign out_row[gj*AW +: AW] = acc_all[out_idx][gj];
        end
    endgenerate

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Bench for systolic_mm_engine: three instances (signed/32, unsigned/32,
// unsigned/16) share one stimulus stream and are compared against a
// matrix-product reference model.
module tb_systolic_mm_engine;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int KMAX = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [3:0]  k_len;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a_col;
    logic [31:0] b_row;

    logic         ir_s, ov_s, busy_s, done_s;
    logic [1:0]   idx_s;
    logic [127:0] row_s;
    logic         ir_u, ov_u, busy_u, done_u;
    logic [1:0]   idx_u;
    logic [127:0] row_u;
    logic         ir_w, ov_w, busy_w, done_w;
    logic [1:0]   idx_w;
    logic [63:0]  row_w;

    systolic_mm_engine #(.N(N), .DW(DW), .AW(32), .KMAX(KMAX), .SIGNED(1)) u_s (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(ir_s), .a_col(a_col), .b_row(b_row),
        .out_valid(ov_s), .out_ready(out_ready), .out_row(row_s), .out_idx(idx_s),
        .busy(busy_s), .done(done_s));

    systolic_mm_engine #(.N(N), .DW(DW), .AW(32), .KMAX(KMAX), .SIGNED(0)) u_u (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(ir_u), .a_col(a_col), .b_row(b_row),
        .out_valid(ov_u), .out_ready(out_ready), .out_row(row_u), .out_idx(idx_u),
        .busy(busy_u), .done(done_u));

    systolic_mm_engine #(.N(N), .DW(DW), .AW(16), .KMAX(KMAX), .SIGNED(0)) u_w (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(ir_w), .a_col(a_col), .b_row(b_row),
        .out_valid(ov_w), .out_ready(out_ready), .out_row(row_w), .out_idx(idx_w),
        .busy(busy_w), .done(done_w));

    int checks   = 0;
    int failures = 0;

    logic [7:0]  am [4][16];
    logic [7:0]  bm [16][4];
    logic [63:0] cs [4][4];
    logic [63:0] cu [4][4];
    logic [63:0] cw [4][4];

    typedef struct {
        int     klen;
        int     pin;
        int     pout;
        int     mode;
        int     exp_lat;
        longint exp_s;
        longint exp_u;
        longint exp_w;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // mode 0 random, 1 identity A with ramp B, 2 all 0x80, 3 all 0xFF
    task automatic fill(input int mode);
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 16; k++) begin
                case (mode)
                    1:       begin am[i][k] = (i == k) ? 8'd1 : 8'd0; bm[k][i] = 8'(4*k + i); end
                    2:       begin am[i][k] = 8'h80; bm[k][i] = 8'h80; end
                    3:       begin am[i][k] = 8'hFF; bm[k][i] = 8'hFF; end
                    default: begin am[i][k] = 8'($urandom); bm[k][i] = 8'($urandom); end
                endcase
            end
        end
    endtask

    // C = A*B over the first keff beats, reduced to each instance's width.
    task automatic compute(input int keff);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                longint ss = 0;
                longint su = 0;
                for (int k = 0; k < keff; k++) begin
                    ss += longint'($signed(am[i][k])) * longint'($signed(bm[k][j]));
                    su += longint'(am[i][k]) * longint'(bm[k][j]);
                end
                cs[i][j] = 64'(ss) & 64'hFFFF_FFFF;
                cu[i][j] = 64'(su) & 64'hFFFF_FFFF;
                cw[i][j] = 64'(su) & 64'h0000_FFFF;
            end
        end
    endtask

    task automatic drive_beat(input int b);
        for (int i = 0; i < 4; i++) begin
            a_col[i*8 +: 8] = (b < 16) ? am[i][b] : 8'h00;
            b_row[i*8 +: 8] = (b < 16) ? bm[b][i] : 8'h00;
        end
    endtask

    task automatic run_job(input int klen, input int pin, input int pout,
                           output int lat, output int dlat,
                           output logic [63:0] c0s, output logic [63:0] c0u, output logic [63:0] c0w);
        int keff  = (klen > KMAX) ? KMAX : klen;
        int beats = 0;
        int row   = 0;
        int cyc   = 1;
        int first = -1;
        int dcyc  = -1;
        bit fin   = 0;
        bit hs;
        bit stalled = 0;
        logic [127:0] prev_row = '0;
        logic [1:0]   prev_idx = '0;
        c0s = '0; c0u = '0; c0w = '0;
        compute(keff);
        @(negedge clk);
        start = 1'b1; k_len = 4'(klen); in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 400) begin
            if (ov_s && first < 0) first = cyc;
            if (ov_s) begin
                if (stalled) begin
                    chk("drain_row_stable", row_s, prev_row);
                    chk("drain_idx_stable", 128'(idx_s), 128'(prev_idx));
                end
                chk("out_idx_order", 128'(idx_s), 128'(row));
            end
            chk("no_early_done", 128'(done_s), 128'(0));
            in_valid  = ($urandom_range(99) < pin);
            out_ready = ($urandom_range(99) < pout);
            start     = ($urandom_range(3) == 0);
            k_len     = 4'($urandom);
            drive_beat(beats);
            if (in_valid && ir_s) beats++;
            hs = ov_s && out_ready;
            if (hs) begin
                for (int j = 0; j < 4; j++) begin
                    chk($sformatf("c_s[%0d][%0d]", row, j), 128'(row_s[j*32 +: 32]), 128'(cs[row][j]));
                    chk($sformatf("c_u[%0d][%0d]", row, j), 128'(row_u[j*32 +: 32]), 128'(cu[row][j]));
                    chk($sformatf("c_w[%0d][%0d]", row, j), 128'(row_w[j*16 +: 16]), 128'(cw[row][j]));
                end
                if (row == 0) begin
                    c0s = 64'(row_s[31:0]);
                    c0u = 64'(row_u[31:0]);
                    c0w = 64'(row_w[15:0]);
                end
                row++;
            end
            stalled  = ov_s && !out_ready;
            prev_row = row_s;
            prev_idx = idx_s;
            @(negedge clk);
            cyc++;
            if (hs && row == 4) begin
                fin  = 1;
                dcyc = cyc;
                start = 1'b0;
                chk("done_pulse", 128'(done_s), 128'(1));
                chk("busy_fall", 128'(busy_s), 128'(0));
                chk("ov_fall", 128'(ov_s), 128'(0));
                chk("ir_idle", 128'(ir_s), 128'(0));
            end
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        if (!fin) begin
            chk("job_timeout", 128'(0), 128'(1));
        end else begin
            @(negedge clk);
            chk("done_single_cycle", 128'(done_s), 128'(0));
        end
        chk("beats_accepted", 128'(beats), 128'(keff));
        lat  = first - 1;
        dlat = dcyc - first;
    endtask

    initial begin
        int lat, dlat;
        logic [63:0] c0s, c0u, c0w;
        int beats, cyc;

        rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b0;
        a_col = '0; b_row = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 128'(ir_s), 128'(0));
        chk("rst_out_valid", 128'(ov_s), 128'(0));
        chk("rst_busy", 128'(busy_s), 128'(0));
        chk("rst_done", 128'(done_s), 128'(0));
        chk("rst_out_idx", 128'(idx_s), 128'(0));
        chk("rst_out_row", row_s, 128'(0));

        vecs[0] = '{4,  100, 100, 1, 12, 0,     0,      0};
        vecs[1] = '{4,  100, 100, 2, 12, 65536, 65536,  0};
        vecs[2] = '{2,  100, 100, 3, 10, 2,     130050, 64514};
        vecs[3] = '{0,  100, 100, 0, 1,  0,     0,      0};
        vecs[4] = '{15, 100, 100, 0, 16, -1,    -1,     -1};
        vecs[5] = '{7,  50,  30,  0, -1, -1,    -1,     -1};
        vecs[6] = '{7,  50,  30,  0, -1, -1,    -1,     -1};
        vecs[7] = '{8,  70,  60,  0, -1, -1,    -1,     -1};
        vecs[8] = '{3,  100, 30,  0, 11, -1,    -1,     -1};
        vecs[9] = '{1,  100, 100, 0, 9,  -1,    -1,     -1};

        for (int v = 0; v < 10; v++) begin
            fill(vecs[v].mode);
            run_job(vecs[v].klen, vecs[v].pin, vecs[v].pout, lat, dlat, c0s, c0u, c0w);
            if (vecs[v].exp_lat >= 0)
                chk($sformatf("latency_v%0d", v), 128'(lat), 128'(vecs[v].exp_lat));
            if (vecs[v].pout == 100)
                chk($sformatf("drain_len_v%0d", v), 128'(dlat), 128'(4));
            if (vecs[v].exp_s >= 0) begin
                chk($sformatf("c00_s_v%0d", v), 128'(c0s), 128'(vecs[v].exp_s));
                chk($sformatf("c00_u_v%0d", v), 128'(c0u), 128'(vecs[v].exp_u));
                chk($sformatf("c00_w_v%0d", v), 128'(c0w), 128'(vecs[v].exp_w));
            end
        end

        // Abort in FEED after two beats, then a clean job must still be correct.
        fill(0);
        @(negedge clk);
        start = 1'b1; k_len = 4'd4;
        @(negedge clk);
        start = 1'b0;
        beats = 0; cyc = 0;
        while (beats < 2 && cyc < 50) begin
            in_valid = 1'b1;
            drive_beat(beats);
            if (ir_s) beats++;
            @(negedge clk);
            cyc++;
        end
        chk("abort_reached_beat2", 128'(beats), 128'(2));
        chk("abort_in_feed", 128'(ir_s), 128'(1));
        rst = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("abort_busy", 128'(busy_s), 128'(0));
        chk("abort_in_ready", 128'(ir_s), 128'(0));
        chk("abort_done", 128'(done_s), 128'(0));
        chk("abort_out_valid", 128'(ov_s), 128'(0));
        chk("abort_out_row", row_s, 128'(0));
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("abort_no_done", 128'(done_s), 128'(0));
        chk("abort_stays_idle", 128'(busy_s), 128'(0));
        fill(0);
        run_job(4, 60, 50, lat, dlat, c0s, c0u, c0w);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
